// File: rtl/dma_store_pkg.sv
// Shared constants and helpers for the DMA word store.
// Default geometry plus the zero-data word returned for empty slots.
package dma_store_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 192;
  localparam int DEF_ADDR_W = 8;

  function automatic logic [DEF_DATA_W-1:0] zero_word();
    return '0;
  endfunction

endpackage

// File: rtl/dma_word_store_if.sv
// Strobe/read bus between the DMA channel logic and the word store.
// master = channel controller and drain side, slave = store.
interface dma_word_store_if
  import dma_store_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              free_en;
  logic [ADDR_W-1:0] free_addr;
  logic              clr;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [ADDR_W-1:0] first_empty;
  logic [ADDR_W-1:0] used_count;
  logic              full;
  logic              addr_err;

  modport master (
    output wr_en, wr_addr, wr_data,
    output free_en, free_addr, clr,
    output rd_en, rd_addr,
    input  rd_data, rd_valid,
    input  first_empty, used_count,
    input  full, addr_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  free_en, free_addr, clr,
    input  rd_en, rd_addr,
    output rd_data, rd_valid,
    output first_empty, used_count,
    output full, addr_err
  );

endinterface

// File: rtl/dma_first_zero_enc.sv
// Lowest-zero priority encoder over the occupancy vector.
// Returns DEPTH when every bit is set.
module dma_first_zero_enc #(
  parameter int DEPTH  = 192,
  parameter int ADDR_W = 8
) (
  input  logic [DEPTH-1:0]  vec,
  output logic [ADDR_W-1:0] idx
);

  always_comb begin
    idx = ADDR_W'(DEPTH);
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!vec[i]) idx = ADDR_W'(i);
    end
  end

endmodule

// File: rtl/dma_word_store.sv
// Word RAM with occupancy bits, registered free pointer and count.
// Reads are read-first; empty or out-of-range words read as zero.
module dma_word_store
  import dma_store_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic       clk,
  input logic       rst,
  dma_word_store_if.slave bus
);

  localparam logic [ADDR_W-1:0] LIM = ADDR_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  occ;
  logic [DEPTH-1:0]  occ_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nxt;
  logic [ADDR_W-1:0] fe;
  logic [ADDR_W-1:0] fe_nxt;
  logic              full_q;
  logic [DATA_W-1:0] rdat;
  logic              rvld;
  logic              aerr;

  logic wr_ok, fr_ok, rd_ok;
  logic do_wr, do_fr;
  logic inc, dec;

  assign wr_ok = bus.wr_en && (bus.wr_addr < LIM);
  assign fr_ok = bus.free_en && (bus.free_addr < LIM);
  assign rd_ok = bus.rd_addr < LIM;

  // clr drops same-cycle writes/frees; a same-address write beats the free
  assign do_wr = wr_ok && !bus.clr;
  assign do_fr = fr_ok && !bus.clr &&
                 !(do_wr && bus.free_addr == bus.wr_addr);

  assign inc = do_wr && !occ[bus.wr_addr];
  assign dec = do_fr && occ[bus.free_addr];

  always_comb begin
    occ_nxt = occ;
    cnt_nxt = cnt;
    if (bus.clr) begin
      occ_nxt = '0;
      cnt_nxt = '0;
    end else begin
      if (do_fr) occ_nxt[bus.free_addr] = 1'b0;
      if (do_wr) occ_nxt[bus.wr_addr] = 1'b1;
      cnt_nxt = cnt + ADDR_W'(inc) - ADDR_W'(dec);
    end
  end

  dma_first_zero_enc #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_enc (
    .vec (occ_nxt),
    .idx (fe_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst && do_wr) mem[bus.wr_addr] <= bus.wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ    <= '0;
      cnt    <= '0;
      fe     <= '0;
      full_q <= 1'b0;
      rdat   <= DATA_W'(zero_word());
      rvld   <= 1'b0;
      aerr   <= 1'b0;
    end else begin
      occ    <= occ_nxt;
      cnt    <= cnt_nxt;
      fe     <= fe_nxt;
      full_q <= (cnt_nxt == LIM);
      rvld   <= bus.rd_en;
      aerr   <= (bus.wr_en && !(bus.wr_addr < LIM)) ||
                (bus.free_en && !(bus.free_addr < LIM)) ||
                (bus.rd_en && !rd_ok);
      if (bus.rd_en) begin
        if (rd_ok && occ[bus.rd_addr])
          rdat <= mem[bus.rd_addr];
        else
          rdat <= DATA_W'(zero_word());
      end
    end
  end

  assign bus.rd_data     = rdat;
  assign bus.rd_valid    = rvld;
  assign bus.first_empty = fe;
  assign bus.used_count  = cnt;
  assign bus.full        = full_q;
  assign bus.addr_err    = aerr;

endmodule

// File: tb/tb_dma_word_store.sv
// Randomised + directed bench for dma_word_store.
// Reference keeps a word array and occupancy set, checked every cycle.
module tb_dma_word_store;

  localparam int DW = 32;
  localparam int D  = 192;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dma_word_store_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  dma_word_store #(
    .DATA_W (DW),
    .DEPTH  (D),
    .ADDR_W (AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0] m_mem [D];
  bit            m_occ [D];
  logic [DW-1:0] m_rd;
  bit            m_rdv;
  bit            m_err;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < D; i++) c += int'(m_occ[i]);
    return c;
  endfunction

  function automatic int m_first();
    for (int i = 0; i < D; i++) if (!m_occ[i]) return i;
    return D;
  endfunction

  task automatic cyc(input bit r,
                     input bit we, input int wa, input logic [DW-1:0] wd,
                     input bit fe, input int fa,
                     input bit cl,
                     input bit re, input int ra);
    rst           = r;
    bus.wr_en     = we;
    bus.wr_addr   = AW'(wa);
    bus.wr_data   = wd;
    bus.free_en   = fe;
    bus.free_addr = AW'(fa);
    bus.clr       = cl;
    bus.rd_en     = re;
    bus.rd_addr   = AW'(ra);
    @(posedge clk);
    #1;
    if (r) begin
      for (int i = 0; i < D; i++) m_occ[i] = 0;
      m_rd  = '0;
      m_rdv = 0;
      m_err = 0;
    end else begin
      m_err = (we && wa >= D) || (fe && fa >= D) || (re && ra >= D);
      m_rdv = re;
      if (re) m_rd = (ra < D && m_occ[ra]) ? m_mem[ra] : '0;
      if (cl) begin
        for (int i = 0; i < D; i++) m_occ[i] = 0;
      end else begin
        if (fe && fa < D) m_occ[fa] = 0;
        if (we && wa < D) begin
          m_occ[wa] = 1;
          m_mem[wa] = wd;
        end
      end
    end
    check("used_count", 32'(bus.used_count), 32'(m_count()));
    check("first_empty", 32'(bus.first_empty), 32'(m_first()));
    check("full", 32'(bus.full), 32'(m_count() == D));
    check("rd_valid", 32'(bus.rd_valid), 32'(m_rdv));
    check("rd_data", bus.rd_data, m_rd);
    check("addr_err", 32'(bus.addr_err), 32'(m_err));
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    cyc(0, 1, a, d, 0, 0, 0, 0, 0);
  endtask

  task automatic rd(input int a);
    cyc(0, 0, 0, '0, 0, 0, 0, 1, a);
  endtask

  initial begin
    m_rd = '0;
    cyc(1, 0, 0, '0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, '0, 0, 0, 0, 0, 0);
    check("rst_count", 32'(bus.used_count), 32'd0);

    wr(1, 8);
    wr(2, 9);
    wr(3, 12);
    check("fe_gap0", 32'(bus.first_empty), 32'd0);
    check("cnt3", 32'(bus.used_count), 32'd3);
    wr(0, 32'h77);
    check("fe4", 32'(bus.first_empty), 32'd4);

    rd(1);
    check("rd1", bus.rd_data, 32'd8);
    rd(5);
    check("rd5_empty", bus.rd_data, 32'd0);
    cyc(0, 1, 2, 32'h55, 0, 0, 0, 1, 2);
    check("rd_first", bus.rd_data, 32'd9);
    rd(2);
    check("rd2_new", bus.rd_data, 32'h55);

    cyc(0, 1, 1, 32'hA1, 1, 1, 0, 0, 0);
    check("wr_beats_free", 32'(bus.used_count), 32'd4);
    cyc(0, 0, 0, '0, 1, 2, 0, 0, 0);
    check("fe_after_free", 32'(bus.first_empty), 32'd2);
    check("cnt_after_free", 32'(bus.used_count), 32'd3);

    for (int i = 0; i < D; i++) wr(i, 32'(i * 3 + 1));
    check("full", 32'(bus.full), 32'd1);
    check("fe_full", 32'(bus.first_empty), 32'(D));
    wr(D, 32'hDEAD);
    check("oob_err", 32'(bus.addr_err), 32'd1);
    rd(D + 3);
    check("oob_rd", bus.rd_data, 32'd0);

    cyc(0, 1, 7, 32'hBEEF, 0, 0, 1, 0, 0);
    check("clr_cnt", 32'(bus.used_count), 32'd0);
    rd(7);
    check("clr_rd7", bus.rd_data, 32'd0);

    wr(4, 32'h44);
    rd(4);
    cyc(1, 1, 9, 32'h99, 1, 4, 0, 1, 4);
    check("rst_mid_rdv", 32'(bus.rd_valid), 32'd0);
    rd(9);
    check("rst_mid_rd9", bus.rd_data, 32'd0);

    for (int n = 0; n < 3000; n++) begin
      bit rr, we, fe, cl, re;
      int hi;
      hi = (n % 500 < 250) ? 199 : 15;
      rr = ($urandom_range(0, 199) == 0);
      we = ($urandom_range(0, 99) < 60);
      fe = ($urandom_range(0, 99) < 30);
      cl = ($urandom_range(0, 149) == 0);
      re = ($urandom_range(0, 99) < 50);
      cyc(rr, we, $urandom_range(0, hi), $urandom,
          fe, $urandom_range(0, hi), cl, re, $urandom_range(0, hi));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_word_store.md
# dma_word_store

Parametrised word store for the DMA datapath: synchronous single-write / single-read RAM with per-word occupancy tracking. It keeps a registered lowest-free-slot pointer, an occupancy count and a full flag so the DMA engine can allocate buffer slots without scanning memory. It sits between the DMA channel controller (writer/freer) and the bus-side drain logic (reader).

## Interface
- DATA_W, 32, word width in bits
- DEPTH, 192, number of words; must satisfy 2 ≤ DEPTH < 2**ADDR_W
- ADDR_W, 8, address width; also the width of first_empty and used_count
- clk  in  1  rising-edge clock; the only clock in the block
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- free_en  in  1  release one slot
- free_addr  in  ADDR_W  slot to release
- clr  in  1  release all slots
- rd_en  in  1  read strobe
- rd_addr  in  ADDR_W  read address
- rd_data  out  DATA_W  read data, valid while rd_valid=1
- rd_valid  out  1  one-cycle pulse per accepted read
- first_empty  out  ADDR_W  lowest unoccupied index; DEPTH when full
- used_count  out  ADDR_W  number of occupied words, 0..DEPTH
- full  out  1  used_count == DEPTH
- addr_err  out  1  one-cycle pulse for an out-of-range access

## Operation
- State: mem[DEPTH] (not reset), occ[DEPTH] bit vector, used_count, first_empty, rd_data, rd_valid.
- Write: wr_en with wr_addr < DEPTH stores wr_data and sets occ[wr_addr]. A write to an occupied word overwrites it; the count is unchanged.
- Free: free_en with free_addr < DEPTH clears occ[free_addr]. Data is left in place.
- Clear: clr zeroes all occ bits. It has priority: any wr_en or free_en in the same cycle is dropped, including the data store.
- Write and free on the same address in the same cycle: the write wins and the word stays occupied.
- used_count next = current + (write to a previously unoccupied word) − (free of a previously occupied word, not overridden by a same-address write). A write and a free in the same cycle on different addresses can leave the count unchanged.
- Read: rd_en with rd_addr < DEPTH returns mem[rd_addr] if occ[rd_addr]=1, otherwise all zeros. Reads are read-first: a read and a write to the same address in the same cycle return the old contents and the old occupancy.
- Out of range: any strobe whose address is ≥ DEPTH is ignored. It sets addr_err for one cycle; a read also produces rd_valid=1 with rd_data=0.
- first_empty: priority encode of the lowest zero in the next-state occ vector; equals DEPTH when every bit is set.

## Timing
- Reset values: occ all 0, used_count 0, first_empty 0, full 0, rd_valid 0, rd_data 0, addr_err 0. mem contents are not reset, but are unobservable because reads of unoccupied words return 0.
- Reset asserted mid-operation discards all same-cycle strobes.
- Write, free and clear take effect at the strobe edge. first_empty, used_count and full reflect that edge in the following cycle (latency 1).
- Read latency is 1: rd_data and rd_valid are registered. rd_data holds its value until the next accepted read; rd_valid is a one-cycle pulse.
- All three strobes may be active every cycle; no back-pressure, no stall.

## Structure
- Package dma_store_pkg holds the default DATA_W/DEPTH/ADDR_W constants and a function for the zero-data word.
- Sub-module dma_first_zero_enc: parametrised combinational lowest-zero priority encoder over DEPTH bits, output width ADDR_W, outputs DEPTH on all-ones. It is instantiated once on the next-state occ vector, with its output registered in dma_word_store.

## Test plan
- Reset, then write 8→addr1, 9→addr2, 12→addr3 -> first_empty 0 and used_count 3. Then write addr0 -> first_empty 4, used_count 4.
- After the above, read addr1 -> rd_data 8 with rd_valid one cycle later. Read addr5 -> rd_data 0. Write 0x55 to addr2 while reading addr2 in the same cycle -> read returns 9.
- Free addr1 and write addr1 in the same cycle -> occ[1] stays 1, used_count unchanged. Free addr2 alone -> first_empty 2, used_count −1.
- Fill all 192 slots -> full=1, first_empty=192. A write to addr 192 -> addr_err pulse, no count change.
- Issue clr together with a write to addr7 -> used_count 0, first_empty 0; a subsequent read of addr7 returns 0.
- Assert rst mid-stream while a write, free and read are all active -> every output is at its reset value the next cycle and the strobes have no effect.
